// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit controller.
package rob_pkg;

  localparam int ROB_ENTRIES = 64;
  localparam int ROB_TAG_W   = $clog2(ROB_ENTRIES);
  localparam int ROB_REG_W   = 6;
  localparam int ROB_DATA_W  = 32;

  typedef logic [ROB_TAG_W-1:0]  tag_t;
  typedef logic [ROB_REG_W-1:0]  reg_idx_t;
  typedef logic [ROB_DATA_W-1:0] data_t;
  typedef logic [ROB_TAG_W:0]    ptr_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    reg_idx_t rd;
    data_t    data;
  } rob_entry_t;

  // Slot index of a wrap-bit pointer (drops the wrap bit).
  function automatic tag_t ptr_idx(input ptr_t p);
    return p[ROB_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/rob_ring_ptr.sv
// Wrap-bit ring pointer: the low bits index the ring, the MSB toggles on each lap
// so that full and empty can be told apart when the indices match.
module rob_ring_ptr #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Pointer register; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer controller driving the register-file write port.
// Optional feature macro: ROB_COMMIT_BYPASS_EN lets a completion that targets the
// not-yet-done head entry retire in the same cycle, using the result bus data.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int REG_W   = ROB_REG_W,
  parameter int DATA_W  = ROB_DATA_W,
  localparam int TAG_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mispred,
  input  logic              alloc_req,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ok,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_write_reg,
  output logic [TAG_W-1:0]  rf_write_tag,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [TAG_W:0]    rob_count,
  output logic              rob_full,
  output logic              rob_empty
);

  ptr_t       head_ptr;
  ptr_t       tail_ptr;
  tag_t       head_idx;
  tag_t       tail_idx;
  rob_entry_t ent [ROB_ENTRIES];
  rob_entry_t head_ent;
  logic       bypass_hit;
  logic       retire;

  rob_ring_ptr #(.W(ROB_TAG_W + 1)) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mispred),
    .inc     (retire),
    .ptr     (head_ptr)
  );

  rob_ring_ptr #(.W(ROB_TAG_W + 1)) u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mispred),
    .inc     (alloc_ok),
    .ptr     (tail_ptr)
  );

  assign head_idx = ptr_idx(head_ptr);
  assign tail_idx = ptr_idx(tail_ptr);
  assign head_ent = ent[head_idx];

  // Occupancy comes from start-of-cycle pointers only, so a slot freed by this
  // cycle's retire is not offered to this cycle's allocation.
  assign rob_count = tail_ptr - head_ptr;
  assign rob_empty = (tail_ptr == head_ptr);
  assign rob_full  = (tail_idx == head_idx) && (tail_ptr[ROB_TAG_W] != head_ptr[ROB_TAG_W]);

`ifdef ROB_COMMIT_BYPASS_EN
  assign bypass_hit = head_ent.valid && !head_ent.done && cdb_valid && (cdb_tag == head_idx);
`else
  assign bypass_hit = 1'b0;
`endif

  assign retire    = !mispred && head_ent.valid && (head_ent.done || bypass_hit);
  assign alloc_ok  = alloc_req && !rob_full && !mispred;
  assign alloc_tag = tail_idx;

  // Retire port mirrors the head entry; writes to r0 retire silently.
  always_comb begin
    rf_we         = retire && (head_ent.rd != '0);
    rf_write_reg  = head_ent.rd;
    rf_write_tag  = head_idx;
    rf_write_data = bypass_hit ? cdb_data : head_ent.data;
  end

  // Entry storage: flush drops every entry, otherwise completion, retire and
  // allocation touch their own slots (allocation never hits a valid slot).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        ent[i] <= '0;
      end
    end else if (mispred) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      if (cdb_valid && ent[cdb_tag].valid) begin
        ent[cdb_tag].done <= 1'b1;
        ent[cdb_tag].data <= cdb_data;
      end
      if (retire) begin
        ent[head_idx].valid <= 1'b0;
        ent[head_idx].done  <= 1'b0;
      end
      if (alloc_ok) begin
        ent[tail_idx] <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd, data: '0};
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: a queue-based ROB model predicts every
// cycle's outputs; a monitor pops and compares just before each rising edge.
module tb_rob_commit_ctrl;

  localparam int N = 64;
`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        mispred;
  logic        alloc_req;
  logic [5:0]  alloc_rd;
  logic        alloc_ok;
  logic [5:0]  alloc_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        rf_we;
  logic [5:0]  rf_write_reg;
  logic [5:0]  rf_write_tag;
  logic [31:0] rf_write_data;
  logic [6:0]  rob_count;
  logic        rob_full;
  logic        rob_empty;

  rob_commit_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mispred       (mispred),
    .alloc_req     (alloc_req),
    .alloc_rd      (alloc_rd),
    .alloc_ok      (alloc_ok),
    .alloc_tag     (alloc_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .rf_we         (rf_we),
    .rf_write_reg  (rf_write_reg),
    .rf_write_tag  (rf_write_tag),
    .rf_write_data (rf_write_data),
    .rob_count     (rob_count),
    .rob_full      (rob_full),
    .rob_empty     (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rd;
    bit          done;
    logic [31:0] data;
  } mentry_t;

  typedef struct {
    bit          ok;
    int          tag;
    int          cnt;
    bit          full;
    bit          empty;
    bit          we;
    int          rreg;
    int          wtag;
    logic [31:0] data;
  } exp_t;

  mentry_t mq[$];
  exp_t    sb[$];
  int      mhead = 0;
  int      mtail = 0;
  int      total = 0;
  int      bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model at the edge.
  task automatic step(input bit mp, input bit req, input int rd,
                      input bit cv, input int ctag, input logic [31:0] cdata);
    exp_t        e;
    bit          ret;
    int          sz;
    int          off;
    mentry_t     ne;
    mispred   = mp;
    alloc_req = req;
    alloc_rd  = 6'(rd);
    cdb_valid = cv;
    cdb_tag   = 6'(ctag);
    cdb_data  = cdata;
    sz      = mq.size();
    e.ok    = req && (sz < N) && !mp;
    e.tag   = mtail;
    e.cnt   = sz;
    e.full  = (sz == N);
    e.empty = (sz == 0);
    e.wtag  = mhead;
    e.rreg  = 0;
    e.data  = '0;
    ret     = 1'b0;
    if (!mp && sz > 0) begin
      if (mq[0].done) begin
        ret    = 1'b1;
        e.data = mq[0].data;
      end else if (BYP && cv && ctag == mhead) begin
        ret    = 1'b1;
        e.data = cdata;
      end
      e.rreg = mq[0].rd;
    end
    e.we = ret && (e.rreg != 0);
    sb.push_back(e);
    @(posedge clk);
    if (mp) begin
      mq.delete();
      mhead = 0;
      mtail = 0;
    end else begin
      if (cv) begin
        off = (ctag - mhead + N) % N;
        if (off < sz) begin
          mq[off].done = 1'b1;
          mq[off].data = cdata;
        end
      end
      if (ret) begin
        void'(mq.pop_front());
        mhead = (mhead + 1) % N;
      end
      if (e.ok) begin
        ne.rd   = rd;
        ne.done = 1'b0;
        ne.data = '0;
        mq.push_back(ne);
        mtail = (mtail + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest prediction 1 time unit before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alloc_ok", 32'(alloc_ok), 32'(e.ok));
        chk("alloc_tag", 32'(alloc_tag), 32'(e.tag));
        chk("rob_count", 32'(rob_count), 32'(e.cnt));
        chk("rob_full", 32'(rob_full), 32'(e.full));
        chk("rob_empty", 32'(rob_empty), 32'(e.empty));
        chk("rf_we", 32'(rf_we), 32'(e.we));
        if (e.we) begin
          chk("rf_write_reg", 32'(rf_write_reg), 32'(e.rreg));
          chk("rf_write_tag", 32'(rf_write_tag), 32'(e.wtag));
          chk("rf_write_data", rf_write_data, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    int ct;
    reset_n   = 1'b0;
    mispred   = 1'b0;
    alloc_req = 1'b0;
    alloc_rd  = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset rob_empty", 32'(rob_empty), 32'd1);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset alloc_tag", 32'(alloc_tag), 32'd0);
    chk("reset rob_count", 32'(rob_count), 32'd0);
    chk("reset rob_full", 32'(rob_full), 32'd0);
    chk("reset alloc_ok", 32'(alloc_ok), 32'd0);
    reset_n = 1'b1;

    // Single instruction round trip.
    step(0, 1, 5, 0, 0, 32'h0);
    step(0, 0, 0, 1, 0, 32'hDEADBEEF);
    idle();
    idle();

    // Out-of-order completion from a clean ROB.
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0);
    step(0, 1, 2, 0, 0, 32'h0);
    step(0, 1, 3, 0, 0, 32'h0);
    step(0, 0, 0, 1, 2, 32'h22222222);
    step(0, 0, 0, 1, 1, 32'h11111111);
    step(0, 0, 0, 1, 0, 32'h00000000);
    repeat (4) idle();

    // Fill to full, then a retire in the same cycle as a refused allocation.
    step(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < N; i++) step(0, 1, (i % 31) + 1, 0, 0, 32'h0);
    step(0, 1, 7, 0, 0, 32'h0);
    step(0, 1, 8, 1, 0, 32'hA5A5A5A5);
    step(0, 1, 9, 0, 0, 32'h0);
    idle();
    step(1, 0, 0, 0, 0, 32'h0);

    // Continuous alloc/complete pairs wrapping the tag space, then flush with live entries.
    for (int i = 0; i < 70; i++) step(0, 1, (i % 62) + 1, 1, mhead, $urandom);
    for (int i = 0; i < 10; i++) step(0, 1, 4, 0, 0, 32'h0);
    step(1, 1, 6, 1, mhead, 32'h12345678);
    idle();

    // rd == 0 retires silently; bypass-on-head timing.
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 0, 32'hCAFEF00D);
    idle();
    step(0, 1, 12, 0, 0, 32'h0);
    step(0, 0, 0, 1, mhead, 32'hBEEF0001);
    idle();
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sz = mq.size();
      if (sz > 0 && ($urandom % 4) != 0) ct = (mhead + int'($urandom % sz)) % N;
      else ct = int'($urandom % N);
      step(($urandom % 80) == 0, ($urandom % 4) != 0, int'($urandom % 64),
           ($urandom % 3) != 0, ct, $urandom);
    end
    step(1, 0, 0, 0, 0, 32'h0);
    idle();

    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
